// File: rtl/addsub_nibble_sched.sv
// addsub_nibble_sched
// Two-requester round-robin scheduler in front of a nibble-serial 16-bit
// add/subtract unit. One 4-bit ripple slice handles one nibble per cycle,
// LSB nibble first. The inter-nibble carry is registered between cycles.
module addsub_nibble_sched #(
    parameter logic RR_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        op0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        req1,
    input  logic        op1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] result,
    output logic        carry,
    output logic        overflow,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_idx;
    logic        r_cin;
    logic        r_last;
    logic        r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [11:0] r_acc;
    logic [15:0] r_result;
    logic        r_carry;
    logic        r_overflow;
    logic        r_grant;

    logic        w_any_req;
    logic        w_sel;
    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic        w_cin_nib;
    logic [3:0]  w_sum;
    logic [4:0]  w_c;
    logic        w_cout;
    logic        w_b15_eff;

    assign w_any_req = req0 | req1;
    // On a tie the requester that was not served last wins; otherwise the
    // only active requester wins.
    assign w_sel     = (req0 & req1) ? ~r_last : req1;

    // Nibble operand selection; B is inverted for subtract and the
    // subtract carry-in of 1 enters only at nibble 0.
    assign w_a_nib   = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib   = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_op}};
    assign w_cin_nib = (r_idx == 2'd0) ? r_op : r_cin;
    assign w_b15_eff = r_b[15] ^ r_op;

    // 4-bit ripple full-adder slice
    always_comb begin
        w_c    = '0;
        w_sum  = '0;
        w_c[0] = w_cin_nib;
        for (int unsigned i = 0; i < 4; i++) begin
            w_sum[i]  = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
            w_c[i+1]  = (w_a_nib[i] & w_b_nib[i]) | (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
        end
    end

    assign w_cout = w_c[4];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> CALC (4 nibbles) -> DONE (1 cycle) -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next = ST_CALC;
            ST_CALC: if (r_idx == 2'd3) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant latch, nibble sequencing and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_cin      <= 1'b0;
            r_last     <= RR_RESET;
            r_op       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_grant    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_sel;
                        r_last  <= w_sel;
                        r_op    <= w_sel ? op1 : op0;
                        r_a     <= w_sel ? a1 : a0;
                        r_b     <= w_sel ? b1 : b0;
                        r_idx   <= '0;
                        r_cin   <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_cin <= w_cout;
                    r_idx <= r_idx + 2'd1;
                    case (r_idx)
                        2'd0: r_acc[3:0]  <= w_sum;
                        2'd1: r_acc[7:4]  <= w_sum;
                        2'd2: r_acc[11:8] <= w_sum;
                        default: begin
                            // Top nibble goes straight into the result together
                            // with the final carry and overflow.
                            r_result   <= {w_sum, r_acc};
                            r_carry    <= w_cout;
                            r_overflow <= (r_a[15] == w_b15_eff) && (w_sum[3] != r_a[15]);
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign ack0     = (r_state == ST_DONE) && !r_grant;
    assign ack1     = (r_state == ST_DONE) &&  r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign grant    = r_grant;
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule
